gcm_deadlock_report_collector: RTL and testbench
================================================

# gcm_deadlock_report_collector

Aggregates the per-instance `block` outputs of the HLS deadlock monitors in the GCM_AE_HW_1x4 core. It debounces them over a programmable persistence window, latches which monitor fired first, and hands one deadlock report per event to the debug/status logic over a valid/ready handshake. It sits directly downstream of the idx monitors and upstream of the status register block.

## Interface
- `N_MON`, default 8: number of monitor `block` inputs; range 1..32.
- `PERSIST`, default 1024: consecutive cycles of any-block required to declare deadlock; must be ≥1.
- `IDX_W`, default 5: width of the reported index; must satisfy 2^IDX_W ≥ N_MON.

Ports:
- `clock`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `mon_block`  in  N_MON  `block` outputs of the monitors; bit i = monitor idx i.
- `clear`  in  1  single-cycle pulse; re-arms the collector after a report.
- `deadlock`  out  1  sticky deadlock flag.
- `rpt_valid`  out  1  report available.
- `rpt_ready`  in  1  report consumer ready.
- `rpt_idx`  out  IDX_W  lowest set bit of `mon_block` at detection.
- `rpt_mask`  out  N_MON  snapshot of `mon_block` at detection.
- `det_count`  out  8  saturating count of detections since reset.

## Operation
- `any_blk` = OR of `mon_block`. The persistence counter `cnt` has width ceil(log2(PERSIST+1)) and is internal.
- **IDLE**: `cnt`=0.
  - `any_blk`=1 with PERSIST=1 → DETECT.
  - `any_blk`=1 otherwise → ARMED, `cnt`=1.
- **ARMED**:
  - `any_blk`=0 → IDLE, `cnt`=0.
  - `any_blk`=1 and `cnt`==PERSIST-1 → DETECT.
  - Else `cnt`+1.
  - The index set may change while counting; only the OR matters.
- **Entry into DETECT** (registered on the detecting edge):
  - `rpt_idx` and `rpt_mask` are captured from the `mon_block` sampled on that edge.
  - `deadlock`=1 and `rpt_valid`=1.
  - `det_count` increments, saturating at 255.
- **DETECT**: `rpt_valid` holds, with `rpt_idx`/`rpt_mask` stable, until `rpt_valid & rpt_ready` is sampled, then → REPORTED.
- **REPORTED**: `rpt_valid`=0 and `deadlock` stays 1. `mon_block` is ignored.
- **`clear`**, in any state:
  - Next state IDLE, `cnt`=0, `deadlock`=0, `rpt_valid`=0.
  - `rpt_idx`/`rpt_mask` retain their last values.
  - `det_count` is not affected.
  - `clear` in DETECT abandons the pending report.
- **Priority**: `reset` > `clear` > handshake > detection.
- **Simultaneous events**:
  - `clear` together with `rpt_ready` in DETECT → IDLE; no handshake is counted.
  - `clear` while `any_blk`=1 → IDLE this edge; counting restarts from the next sampled edge.

## Timing
- **Reset values**: all outputs 0 (`deadlock`, `rpt_valid`, `rpt_idx`, `rpt_mask`, `det_count`); state IDLE; `cnt` 0.
- **Detection latency**:
  - `mon_block` ≠0 sampled on edges e0..e(PERSIST-1) → `deadlock`/`rpt_valid` high after edge e(PERSIST-1).
  - For PERSIST=1, high after e0.
- **Debounce**: a single zero-sample of `any_blk` before detection restarts the window.
- **Handshake**: the transfer occurs on the edge where `rpt_valid` and `rpt_ready` are both 1. `rpt_valid` is low the next cycle. `rpt_ready` may be high before `rpt_valid`.
- **Re-detection**: after `clear`, a new detection needs PERSIST full consecutive cycles again.
- `reset` asserted mid-count or mid-report returns everything to reset values on that edge.
- No combinational path from inputs to outputs.

## Test plan
All scenarios use N_MON=8, PERSIST=4 unless stated.
1. **Basic detect and report**: `mon_block`=8'h24 for 4 cycles, `rpt_ready`=1 → `deadlock`=1 and `rpt_valid`=1 after the 4th edge, `rpt_idx`=2, `rpt_mask`=8'h24, `det_count`=1. `rpt_valid` drops the next cycle; `deadlock` stays 1.
2. **Glitch rejection**: `mon_block`=8'h01 for 3 cycles, 8'h00 for 1, then 8'h80 for 3 → `deadlock` never asserts and `cnt` returns to 0. Then 1 more cycle of 8'h80 → detect with `rpt_idx`=7.
3. **Backpressure**: detect with `rpt_ready`=0 for 10 cycles while `mon_block` toggles → `rpt_valid`, `rpt_idx`, `rpt_mask` stable. Raising `rpt_ready` gives exactly one transfer.
4. **Clear priority**: in DETECT, drive `clear`=1 and `rpt_ready`=1 in the same cycle → next cycle IDLE with `deadlock`=0 and `rpt_valid`=0, `det_count` unchanged. Hold `mon_block`=8'h02 → re-detect 4 cycles after `clear` deasserts, `det_count`=2.
5. **Saturation and reset**: perform 256 detect/clear cycles → `det_count`=255. Assert `reset` mid-ARMED → all outputs 0 on the next cycle.
6. **PERSIST=1 build**: `mon_block`=8'h10 for a single cycle → `deadlock`=1 after that edge, `rpt_idx`=4.

Source files
------------

// File: rtl/gcm_deadlock_report_collector.sv
// Debounces the HLS deadlock monitor block flags over a persistence window and
// publishes one latched deadlock report per event over a valid/ready handshake.
module gcm_deadlock_report_collector #(
    parameter int N_MON   = 8,
    parameter int PERSIST = 1024,
    parameter int IDX_W   = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_MON-1:0] mon_block,
    input  logic             clear,
    output logic             deadlock,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [IDX_W-1:0] rpt_idx,
    output logic [N_MON-1:0] rpt_mask,
    output logic [7:0]       det_count
);

    localparam int CNT_W = $clog2(PERSIST + 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ARMED    = 2'd1;
    localparam logic [1:0] S_DETECT   = 2'd2;
    localparam logic [1:0] S_REPORTED = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             any_blk;
    logic [IDX_W-1:0] low_idx;
    logic             detect_now;

    assign any_blk = |mon_block;

    // Scan downward so the last hit written is the lowest set bit.
    always_comb begin
        low_idx = '0;
        for (int i = N_MON - 1; i >= 0; i--) begin
            if (mon_block[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        detect_now = 1'b0;
        if (any_blk) begin
            if (state == S_IDLE && PERSIST == 1) begin
                detect_now = 1'b1;
            end else if (state == S_ARMED && cnt == CNT_W'(PERSIST - 1)) begin
                detect_now = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            deadlock  <= 1'b0;
            rpt_valid <= 1'b0;
            rpt_idx   <= '0;
            rpt_mask  <= '0;
            det_count <= '0;
        end else if (clear) begin
            // Report fields are deliberately retained for post-mortem reads.
            state     <= S_IDLE;
            cnt       <= '0;
            deadlock  <= 1'b0;
            rpt_valid <= 1'b0;
        end else if (detect_now) begin
            state     <= S_DETECT;
            cnt       <= '0;
            deadlock  <= 1'b1;
            rpt_valid <= 1'b1;
            rpt_idx   <= low_idx;
            rpt_mask  <= mon_block;
            if (det_count != 8'hFF) begin
                det_count <= det_count + 8'd1;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_blk) begin
                        state <= S_ARMED;
                        cnt   <= CNT_W'(1);
                    end
                end
                S_ARMED: begin
                    if (!any_blk) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DETECT: begin
                    if (rpt_ready) begin
                        state     <= S_REPORTED;
                        rpt_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= S_REPORTED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcm_deadlock_report_collector.sv
// Bench for the deadlock report collector: a PERSIST=4 instance driven from a
// vector table and hand sequences, plus a PERSIST=1 instance for the fast path.
module tb_gcm_deadlock_report_collector;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] mon_block;
    logic       clear;
    logic       rpt_ready;
    logic       deadlock;
    logic       rpt_valid;
    logic [4:0] rpt_idx;
    logic [7:0] rpt_mask;
    logic [7:0] det_count;

    logic [7:0] mon_block1;
    logic       clear1;
    logic       rpt_ready1;
    logic       deadlock1;
    logic       rpt_valid1;
    logic [4:0] rpt_idx1;
    logic [7:0] rpt_mask1;
    logic [7:0] det_count1;

    always #5 clock = ~clock;

    gcm_deadlock_report_collector #(.N_MON(8), .PERSIST(4), .IDX_W(5)) dut (
        .clock(clock), .reset(reset), .mon_block(mon_block), .clear(clear),
        .deadlock(deadlock), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
        .rpt_idx(rpt_idx), .rpt_mask(rpt_mask), .det_count(det_count)
    );

    gcm_deadlock_report_collector #(.N_MON(8), .PERSIST(1), .IDX_W(5)) dut1 (
        .clock(clock), .reset(reset), .mon_block(mon_block1), .clear(clear1),
        .deadlock(deadlock1), .rpt_valid(rpt_valid1), .rpt_ready(rpt_ready1),
        .rpt_idx(rpt_idx1), .rpt_mask(rpt_mask1), .det_count(det_count1)
    );

    typedef struct {
        logic [7:0] mb;
        logic       clr;
        logic       rdy;
        logic       dl;
        logic       v;
        logic [4:0] idx;
        logic [7:0] mask;
        logic [7:0] cnt;
    } vec_t;

    vec_t        vecs[17];
    logic [22:0] exp_q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;

    function automatic logic [22:0] pk(input logic dl, input logic v, input logic [4:0] idx,
                                       input logic [7:0] mask, input logic [7:0] cnt);
        return {dl, v, idx, mask, cnt};
    endfunction

    function automatic vec_t mk(input logic [7:0] mb, input logic clr, input logic rdy,
                                input logic dl, input logic v, input logic [4:0] idx,
                                input logic [7:0] mask, input logic [7:0] cnt);
        vec_t r;
        r.mb = mb; r.clr = clr; r.rdy = rdy; r.dl = dl; r.v = v;
        r.idx = idx; r.mask = mask; r.cnt = cnt;
        return r;
    endfunction

    task automatic drive(input logic [7:0] mb, input logic clr, input logic rdy, input logic rst);
        @(negedge clock);
        mon_block = mb;
        clear     = clr;
        rpt_ready = rdy;
        reset     = rst;
        @(posedge clock);
        #1;
    endtask

    task automatic compare(input string name, input logic [22:0] act);
        logic [22:0] exp;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: got %h, expected entry missing from queue", name, act);
        end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
                n_fail++;
                $display("FAIL %s: got dl/v/idx/mask/cnt=%h required %h", name, act, exp);
            end
        end
    endtask

    task automatic step_chk(input string name, input logic [7:0] mb, input logic clr,
                            input logic rdy, input logic rst, input logic [22:0] exp);
        exp_q.push_back(exp);
        drive(mb, clr, rdy, rst);
        compare(name, {deadlock, rpt_valid, rpt_idx, rpt_mask, det_count});
    endtask

    initial begin
        logic [7:0] m_cnt;
        logic [7:0] mb;

        vecs[0]  = mk(8'h24, 0, 1, 0, 0, 0, 8'h00, 0);
        vecs[1]  = mk(8'h24, 0, 1, 0, 0, 0, 8'h00, 0);
        vecs[2]  = mk(8'h24, 0, 1, 0, 0, 0, 8'h00, 0);
        vecs[3]  = mk(8'h24, 0, 1, 1, 1, 2, 8'h24, 1);
        vecs[4]  = mk(8'h00, 0, 1, 1, 0, 2, 8'h24, 1);
        vecs[5]  = mk(8'hFF, 0, 1, 1, 0, 2, 8'h24, 1);
        vecs[6]  = mk(8'h00, 1, 0, 0, 0, 2, 8'h24, 1);
        vecs[7]  = mk(8'h01, 0, 1, 0, 0, 2, 8'h24, 1);
        vecs[8]  = mk(8'h01, 0, 1, 0, 0, 2, 8'h24, 1);
        vecs[9]  = mk(8'h01, 0, 1, 0, 0, 2, 8'h24, 1);
        vecs[10] = mk(8'h00, 0, 1, 0, 0, 2, 8'h24, 1);
        vecs[11] = mk(8'h80, 0, 1, 0, 0, 2, 8'h24, 1);
        vecs[12] = mk(8'h80, 0, 1, 0, 0, 2, 8'h24, 1);
        vecs[13] = mk(8'h80, 0, 1, 0, 0, 2, 8'h24, 1);
        vecs[14] = mk(8'h80, 0, 1, 1, 1, 7, 8'h80, 2);
        vecs[15] = mk(8'h00, 0, 1, 1, 0, 7, 8'h80, 2);
        vecs[16] = mk(8'h00, 1, 0, 0, 0, 7, 8'h80, 2);

        mon_block = '0; clear = 0; rpt_ready = 0; reset = 1;
        mon_block1 = '0; clear1 = 0; rpt_ready1 = 0;

        // Reset state, with blocks asserted to show reset wins.
        step_chk("reset_a", 8'hFF, 0, 1, 1, pk(0, 0, 0, 8'h00, 0));
        step_chk("reset_b", 8'h00, 0, 0, 1, pk(0, 0, 0, 8'h00, 0));
        exp_q.push_back(pk(0, 0, 0, 8'h00, 0));
        compare("reset_p1", {deadlock1, rpt_valid1, rpt_idx1, rpt_mask1, det_count1});

        // Basic detect/report then glitch rejection.
        for (int i = 0; i < 17; i++) begin
            step_chk($sformatf("vec%0d", i), vecs[i].mb, vecs[i].clr, vecs[i].rdy, 0,
                     pk(vecs[i].dl, vecs[i].v, vecs[i].idx, vecs[i].mask, vecs[i].cnt));
        end

        // Backpressure: report holds steady while inputs churn.
        for (int i = 0; i < 3; i++)
            step_chk("bp_arm", 8'h03, 0, 0, 0, pk(0, 0, 7, 8'h80, 2));
        step_chk("bp_detect", 8'h03, 0, 0, 0, pk(1, 1, 0, 8'h03, 3));
        for (int i = 0; i < 10; i++)
            step_chk("bp_hold", 8'($urandom_range(0, 255)), 0, 0, 0, pk(1, 1, 0, 8'h03, 3));
        step_chk("bp_xfer", 8'($urandom_range(0, 255)), 0, 1, 0, pk(1, 0, 0, 8'h03, 3));
        for (int i = 0; i < 3; i++)
            step_chk("bp_after", 8'($urandom_range(1, 255)), 0, 1, 0, pk(1, 0, 0, 8'h03, 3));
        step_chk("bp_clear", 8'h00, 1, 0, 0, pk(0, 0, 0, 8'h03, 3));

        // Clear beats handshake in DETECT, then a full re-detect window.
        for (int i = 0; i < 3; i++)
            step_chk("cp_arm", 8'h02, 0, 0, 0, pk(0, 0, 0, 8'h03, 3));
        step_chk("cp_detect", 8'h02, 0, 0, 0, pk(1, 1, 1, 8'h02, 4));
        step_chk("cp_clear_rdy", 8'h02, 1, 1, 0, pk(0, 0, 1, 8'h02, 4));
        for (int i = 0; i < 3; i++)
            step_chk("cp_rearm", 8'h02, 0, 0, 0, pk(0, 0, 1, 8'h02, 4));
        step_chk("cp_redetect", 8'h02, 0, 0, 0, pk(1, 1, 1, 8'h02, 5));
        step_chk("cp_clear2", 8'h02, 1, 0, 0, pk(0, 0, 1, 8'h02, 5));

        // Saturation of det_count across many detect/clear rounds.
        m_cnt = 8'd5;
        for (int k = 0; k < 256; k++) begin
            mb = 8'(1 << (k % 8));
            for (int j = 0; j < 3; j++) drive(mb, 0, 0, 0);
            if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
            step_chk("sat_detect", mb, 0, 0, 0, pk(1, 1, 5'(k % 8), mb, m_cnt));
            step_chk("sat_clear", 8'h00, 1, 0, 0, pk(0, 0, 5'(k % 8), mb, m_cnt));
        end

        // Reset mid-ARMED returns everything to zero.
        drive(8'h01, 0, 0, 0);
        drive(8'h01, 0, 0, 0);
        step_chk("rst_mid", 8'h01, 0, 0, 1, pk(0, 0, 0, 8'h00, 0));
        step_chk("rst_after", 8'h00, 0, 0, 0, pk(0, 0, 0, 8'h00, 0));

        // PERSIST=1 instance: single-cycle block is enough.
        @(negedge clock);
        mon_block1 = 8'h10; rpt_ready1 = 0;
        exp_q.push_back(pk(1, 1, 4, 8'h10, 1));
        @(posedge clock); #1;
        compare("p1_detect", {deadlock1, rpt_valid1, rpt_idx1, rpt_mask1, det_count1});
        @(negedge clock);
        mon_block1 = 8'h00; rpt_ready1 = 1;
        exp_q.push_back(pk(1, 0, 4, 8'h10, 1));
        @(posedge clock); #1;
        compare("p1_xfer", {deadlock1, rpt_valid1, rpt_idx1, rpt_mask1, det_count1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
